mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------------------------------------------------------------------
// MEM-stage data-memory access controller. It turns an aligned LW/SW held in
// the MEM stage into one request on the data-memory channel, waits for the
// acknowledge, and produces the registered writeback-side results. A
// misaligned LW/SW never reaches memory. It is reported on mem_error and
// retires as a bubble. An access that gets no acknowledge for TIMEOUT BUSY
// cycles is abandoned. It also reports mem_error and retires as a bubble.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   MEM_*                 instruction currently held in the MEM stage
//   stall[5:0]            pipeline stall vector; stall[4] freezes MEM/WB
//   stallreq_mem          freeze request for stages 0-3 (combinational)
//   dmem_req/we/addr/wdata  request channel (addr is a word address)
//   dmem_rdata, dmem_ack  response channel
//   WB_result/writeEnable/writeAddress  registered writeback results
//   mem_error             one-cycle pulse: misaligned access or timeout
//   dbg_state             current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Memory handshake: dmem_req is high for every BUSY cycle. While it is high,
// dmem_we/dmem_addr/dmem_wdata do not change. The memory answers with
// dmem_ack for exactly one cycle, and dmem_rdata is valid in that cycle.
// The request ends on the edge that samples the ack. An ack seen while
// dmem_req is low is ignored.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_result,
  input  logic        MEM_writeEnable,
  input  logic [4:0]  MEM_writeAddress,
  input  logic [5:0]  MEM_ALUopcode,
  input  logic [31:0] MEM_memoryAddress,
  input  logic [31:0] MEM_memoryData,
  input  logic [5:0]  stall,
  output logic        stallreq_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] WB_result,
  output logic        WB_writeEnable,
  output logic [4:0]  WB_writeAddress,
  output logic        mem_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  // Set when the access in DONE is a load that completed with data.
  logic        done_wb_q;

  logic is_ls, aligned, memop, misaligned, timeout_hit, wb_upd;

  assign is_ls       = (MEM_ALUopcode == OP_LW) || (MEM_ALUopcode == OP_SW);
  assign aligned     = (MEM_memoryAddress[1:0] == 2'b00);
  assign memop       = is_ls && aligned;
  assign misaligned  = is_ls && !aligned;
  // Ack has priority over the timeout in the last allowed BUSY cycle.
  assign timeout_hit = (state == BUSY) && !dmem_ack && (cnt == 8'(TIMEOUT - 1));
  assign wb_upd      = !stall[4];

  // Only the MEM/WB freeze bit is relevant to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign stallreq_mem = ((state == IDLE) && memop) || (state == BUSY);
  assign dmem_req     = (state == BUSY);
  assign dbg_state    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (memop) state_nxt = BUSY;
      BUSY: if (dmem_ack || timeout_hit) state_nxt = DONE;
      // Leaving DONE always goes through IDLE. A back-to-back access
      // therefore starts one cycle later.
      DONE: if (wb_upd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      rdata_q         <= 32'd0;
      done_wb_q       <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 30'd0;
      dmem_wdata      <= 32'd0;
      WB_result       <= 32'd0;
      WB_writeEnable  <= 1'b0;
      WB_writeAddress <= 5'd0;
      mem_error       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_error <= 1'b0;

      case (state)
        IDLE: begin
          if (memop) begin
            cnt        <= 8'd0;
            dmem_addr  <= MEM_memoryAddress[31:2];
            dmem_wdata <= MEM_memoryData;
            dmem_we    <= (MEM_ALUopcode == OP_SW);
          end else if (misaligned && wb_upd) begin
            // Report once, on the edge where the instruction retires.
            mem_error <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            rdata_q   <= dmem_rdata;
            done_wb_q <= !dmem_we;
          end else if (timeout_hit) begin
            done_wb_q <= 1'b0;
            mem_error <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase

      if (wb_upd) begin
        WB_result       <= 32'd0;
        WB_writeEnable  <= 1'b0;
        WB_writeAddress <= 5'd0;
        if ((state == IDLE) && !is_ls) begin
          WB_result       <= MEM_result;
          WB_writeEnable  <= MEM_writeEnable;
          WB_writeAddress <= MEM_writeAddress;
        end else if ((state == DONE) && done_wb_q) begin
          WB_result       <= rdata_q;
          WB_writeEnable  <= MEM_writeEnable;
          WB_writeAddress <= MEM_writeAddress;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// ---------------------------------------------------------------------------
// Bench for mem_access_unit. It drives one instruction at a time into the MEM
// stage and plays the data memory. The memory acks after a chosen number of
// request cycles. A delay beyond TIMEOUT means the memory never acks. The
// bench also predicts, per instruction, the request count, the freeze-request
// count, the error pulses and the writeback result.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int         TIMEOUT = 16;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic        clk;
  logic        reset;
  logic [31:0] MEM_result;
  logic        MEM_writeEnable;
  logic [4:0]  MEM_writeAddress;
  logic [5:0]  MEM_ALUopcode;
  logic [31:0] MEM_memoryAddress;
  logic [31:0] MEM_memoryData;
  logic [5:0]  stall;
  logic        stallreq_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] WB_result;
  logic        WB_writeEnable;
  logic [4:0]  WB_writeAddress;
  logic        mem_error;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.OP_LW(OP_LW), .OP_SW(OP_SW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MEM_result(MEM_result), .MEM_writeEnable(MEM_writeEnable),
    .MEM_writeAddress(MEM_writeAddress), .MEM_ALUopcode(MEM_ALUopcode),
    .MEM_memoryAddress(MEM_memoryAddress), .MEM_memoryData(MEM_memoryData),
    .stall(stall), .stallreq_mem(stallreq_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .WB_result(WB_result), .WB_writeEnable(WB_writeEnable),
    .WB_writeAddress(WB_writeAddress), .mem_error(mem_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] alu_op();
    logic [5:0] o;
    o = 6'($urandom_range(63));
    if (o == OP_LW || o == OP_SW) o = 6'h20;
    return o;
  endfunction

  // driver: one non-memory instruction, retires on the next edge
  task automatic run_alu(input logic [31:0] res, input logic we, input logic [4:0] wa);
    MEM_ALUopcode     = alu_op();
    MEM_result        = res;
    MEM_writeEnable   = we;
    MEM_writeAddress  = wa;
    MEM_memoryAddress = $urandom;
    MEM_memoryData    = $urandom;
    stall             = {1'($urandom_range(1)), 1'b0, 4'($urandom_range(15))};
    dmem_ack          = 1'b0;
    #1;
    chk("alu_stallreq", stallreq_mem, 0);
    exp_q.push_back(res);
    tick();
    chk("alu_wb_result", WB_result, exp_q.pop_front());
    chk("alu_wb_we", WB_writeEnable, we);
    chk("alu_wb_wa", WB_writeAddress, wa);
  endtask

  // driver + memory model: one LW/SW. ack_delay = BUSY cycle carrying the ack
  // (1 = first request cycle); > TIMEOUT means no ack ever.
  task automatic run_mem(input bit is_lw, input logic [31:0] addr, input logic [31:0] data,
                         input int ack_delay, input logic [31:0] rdata,
                         input logic we_in, input logic [4:0] wa, input int done_stall);
    bit aligned;
    bit timeout;
    bit ok_load;
    int req_cycles;
    int sreq_cycles;
    int err_cycles;
    bit moved;
    aligned     = (addr[1:0] == 2'b00);
    timeout     = (ack_delay > TIMEOUT);
    ok_load     = is_lw && !timeout;
    req_cycles  = 0;
    sreq_cycles = 0;
    err_cycles  = 0;
    moved       = 1'b0;
    MEM_ALUopcode     = is_lw ? OP_LW : OP_SW;
    MEM_memoryAddress = addr;
    MEM_memoryData    = data;
    MEM_result        = $urandom;
    MEM_writeEnable   = we_in;
    MEM_writeAddress  = wa;
    stall             = 6'd0;
    dmem_ack          = 1'b0;
    #1;
    if (!aligned) begin
      chk("mis_stallreq", stallreq_mem, 0);
      chk("mis_req", dmem_req, 0);
      tick();
      chk("mis_err", mem_error, 1);
      chk("mis_wb_we", WB_writeEnable, 0);
      chk("mis_req_after", dmem_req, 0);
      MEM_ALUopcode   = 6'h00;
      MEM_writeEnable = 1'b0;
      tick();
      chk("mis_err_once", mem_error, 0);
      return;
    end
    chk("mem_req_idle", dmem_req, 0);
    if (stallreq_mem) sreq_cycles++;
    tick();
    chk("issue_wb_bubble_we", WB_writeEnable, 0);
    chk("issue_wb_bubble_res", WB_result, 0);
    chk("req_addr", dmem_addr, addr[31:2]);
    chk("req_we", dmem_we, !is_lw);
    chk("req_wdata", dmem_wdata, data);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!dmem_req) break;
      req_cycles++;
      if (stallreq_mem) sreq_cycles++;
      if (mem_error) err_cycles++;
      if (dmem_addr !== addr[31:2] || dmem_we !== !is_lw || dmem_wdata !== data) moved = 1'b1;
      dmem_ack   = (cyc == ack_delay);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      tick();
    end
    // completion cycle: a stray ack here must not disturb the captured data
    dmem_ack   = 1'($urandom_range(1));
    dmem_rdata = $urandom;
    chk("done_state", dbg_state, 2);
    chk("done_stallreq", stallreq_mem, 0);
    if (mem_error) err_cycles++;
    for (int i = 0; i < done_stall; i++) begin
      stall = 6'b010000;
      tick();
      chk("done_hold_state", dbg_state, 2);
      chk("done_hold_wb", WB_writeEnable, 0);
      if (mem_error) err_cycles++;
    end
    stall = 6'd0;
    exp_q.push_back(ok_load ? rdata : 32'd0);
    tick();
    dmem_ack = 1'b0;
    if (ok_load) begin
      chk("lw_wb_result", WB_result, exp_q.pop_front());
      chk("lw_wb_wa", WB_writeAddress, wa);
    end else begin
      void'(exp_q.pop_front());
    end
    chk("mem_wb_we", WB_writeEnable, ok_load ? we_in : 1'b0);
    if (timeout) chk("timeout_wb_result", WB_result, 0);
    chk("back_idle", dbg_state, 0);
    chk("req_dropped", dmem_req, 0);
    if (mem_error) err_cycles++;
    chk("req_cycles", req_cycles, timeout ? TIMEOUT : ack_delay);
    chk("stallreq_cycles", sreq_cycles, (timeout ? TIMEOUT : ack_delay) + 1);
    chk("err_pulses", err_cycles, timeout ? 1 : 0);
    chk("req_fields_stable", moved, 0);
  endtask

  initial begin
    reset = 1'b0;
    MEM_result = 0; MEM_writeEnable = 0; MEM_writeAddress = 0;
    MEM_ALUopcode = 0; MEM_memoryAddress = 0; MEM_memoryData = 0;
    stall = 0; dmem_rdata = 0; dmem_ack = 0;
    repeat (3) tick();
    chk("rst_state", dbg_state, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_result", WB_result, 0);
    chk("rst_wb_we", WB_writeEnable, 0);
    chk("rst_wb_wa", WB_writeAddress, 0);
    chk("rst_err", mem_error, 0);
    reset = 1'b1;

    // plain ALU op
    MEM_ALUopcode = 6'h20; MEM_result = 32'h5; MEM_writeEnable = 1'b1; MEM_writeAddress = 5'd3;
    #1;
    chk("alu36_stallreq", stallreq_mem, 0);
    tick();
    chk("alu36_result", WB_result, 32'h5);
    chk("alu36_we", WB_writeEnable, 1);
    chk("alu36_wa", WB_writeAddress, 3);

    // MEM/WB freeze holds writeback
    MEM_result = 32'hAAAA_5555; MEM_writeEnable = 1'b0; MEM_writeAddress = 5'd9;
    stall = 6'b010000;
    tick();
    chk("hold_result", WB_result, 32'h5);
    chk("hold_we", WB_writeEnable, 1);
    chk("hold_wa", WB_writeAddress, 3);
    stall = 6'd0;
    tick();
    chk("unhold_result", WB_result, 32'hAAAA_5555);

    // reset wins over stall
    run_alu(32'h1234, 1'b1, 5'd17);
    reset = 1'b0; stall = 6'h3F;
    tick();
    chk("rst_prio_result", WB_result, 0);
    chk("rst_prio_we", WB_writeEnable, 0);
    reset = 1'b1; stall = 6'd0;

    run_mem(1'b1, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 5'd7, 0);
    run_mem(1'b0, 32'h0000_0020, 32'h1234_5678, 1, 32'h0, 1'b1, 5'd4, 1);
    run_mem(1'b1, 32'h0000_0013, 32'h0, 1, 32'h0, 1'b1, 5'd2, 0);
    run_mem(1'b1, 32'h0000_0030, 32'h0, 100, 32'h0, 1'b1, 5'd5, 0);
    run_mem(1'b1, 32'h0000_0044, 32'h0, TIMEOUT, 32'h0BAD_F00D, 1'b1, 5'd6, 2);
    run_mem(1'b1, 32'h0000_0048, 32'h0, TIMEOUT + 1, 32'h0, 1'b1, 5'd6, 0);

    // reset in the 2nd BUSY cycle, then a late ack
    MEM_ALUopcode = OP_LW; MEM_memoryAddress = 32'h40; MEM_writeEnable = 1'b1;
    MEM_writeAddress = 5'd8; MEM_result = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy_req", dmem_req, 0);
    chk("rst_busy_state", dbg_state, 0);
    chk("rst_busy_wb_we", WB_writeEnable, 0);
    reset = 1'b1;
    MEM_ALUopcode = 6'h00; MEM_writeEnable = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_state", dbg_state, 0);
    chk("late_ack_wb_we", WB_writeEnable, 0);
    chk("late_ack_wb_result", WB_result, 0);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(3);
      a    = {24'($urandom), 6'($urandom), 2'b00};
      case (kind)
        0: run_alu($urandom, 1'($urandom_range(1)), 5'($urandom_range(31)));
        1: run_mem(1'b1, a, $urandom, $urandom_range(1, 20), $urandom,
                   1'($urandom_range(1)), 5'($urandom_range(31)), $urandom_range(0, 2));
        2: run_mem(1'b0, a, $urandom, $urandom_range(1, 20), $urandom,
                   1'($urandom_range(1)), 5'($urandom_range(31)), $urandom_range(0, 2));
        default: run_mem(1'($urandom_range(1)), {a[31:2], 2'($urandom_range(3))}, $urandom,
                         $urandom_range(1, 20), $urandom, 1'b1,
                         5'($urandom_range(31)), $urandom_range(0, 2));
      endcase
    end

    MEM_ALUopcode = 6'h00;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
